// File: rtl/lfsr_pkg.sv
// ============================================================================
// Module      : lfsr_pkg
// Description : Shared constants, state encoding and step rule for the
//               LFSR random-number arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lfsr_pkg;

  localparam int LFSR_W = 9;
  localparam int TAP_HI = 8;
  localparam int TAP_LO = 3;
  localparam logic [LFSR_W-1:0] LFSR_LOCKUP = 9'h1FF;

  typedef enum logic [1:0] {
    WARMUP  = 2'd0,
    IDLE    = 2'd1,
    ADVANCE = 2'd2
  } arb_state_t;

  // One Fibonacci shift. The XNOR feedback would stay stuck at all-ones
  // forever, so that one state uses plain XOR to fall out of it.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
    logic fb;
    fb = q[TAP_HI] ^ q[TAP_LO];
    if (q != LFSR_LOCKUP) begin
      fb = ~fb;
    end
    return {q[LFSR_W-2:0], fb};
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_core.sv
// ============================================================================
// Module      : lfsr_core
// Description : 9-bit XNOR Fibonacci LFSR with synchronous load, shift enable
//               and all-ones lockup escape.
//               Optional macro LFSR_FREERUN_EN: shift every cycle, ignoring en.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_core
  import lfsr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 9'h0A5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              en,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] q
);

  logic shift_en;

`ifdef LFSR_FREERUN_EN
  // Free-running: the shift request is irrelevant, the register always moves.
  assign shift_en = 1'b1 | en;
`else
  assign shift_en = en;
`endif

  // LFSR register: load wins over shifting.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      q <= SEED;
    end else if (load) begin
      q <= load_val;
    end else if (shift_en) begin
      q <= lfsr_step(q);
    end
  end

endmodule

`default_nettype wire

// File: rtl/lfsr_rand_arbiter.sv
// ============================================================================
// Module      : lfsr_rand_arbiter
// Description : Shares one LFSR between NUM_REQ requesters. Warm-up after
//               reset/seed, round-robin grant of one value per request, then
//               STEP decorrelation shifts before the next grant.
//               Optional macro LFSR_FREERUN_EN (handled in lfsr_core): LFSR
//               also shifts while idle; grant timing is unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_rand_arbiter
  import lfsr_pkg::*;
#(
  parameter int                 NUM_REQ       = 4,
  parameter int                 LFSR_W        = 9,
  parameter logic [LFSR_W-1:0]  SEED          = 9'h0A5,
  parameter int                 WARMUP_CYCLES = 16,
  parameter int                 STEP          = 2
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               seed_load,
  input  logic [LFSR_W-1:0]  seed_val,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] rand_valid,
  output logic [LFSR_W-1:0]  rand_data,
  output logic               busy
);

  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_MAX = (WARMUP_CYCLES > STEP) ? WARMUP_CYCLES : STEP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] LAST_WARM = CNT_W'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEP - 1);
  localparam logic [PTR_W-1:0] LAST_REQ  = PTR_W'(NUM_REQ - 1);

  arb_state_t         state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [NUM_REQ-1:0] rand_valid_nxt;
  logic [LFSR_W-1:0]  rand_data_nxt;
  logic               lfsr_en;
  logic               lfsr_load;
  logic [LFSR_W-1:0]  lfsr_q;
  logic               win_found;
  logic [PTR_W-1:0]   win_idx;

  // First set request at or above ptr, wrapping. Scanning from the far end
  // lets the nearest hit overwrite the others.
  function automatic logic [PTR_W:0] pick_winner(input logic [NUM_REQ-1:0] r,
                                                 input logic [PTR_W-1:0]   p);
    logic [PTR_W:0] res;
    int             j;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = int'(p) + i;
      if (j >= NUM_REQ) begin
        j = j - NUM_REQ;
      end
      if (r[j]) begin
        res = {1'b1, PTR_W'(j)};
      end
    end
    return res;
  endfunction

  assign {win_found, win_idx} = pick_winner(req, rr_ptr);
  assign busy = (state != IDLE);

  lfsr_core #(
    .SEED (SEED)
  ) u_lfsr (
    .Clk      (Clk),
    .Reset    (Reset),
    .en       (lfsr_en),
    .load     (lfsr_load),
    .load_val (seed_val),
    .q        (lfsr_q)
  );

  // Sequencer state and registered grant outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= WARMUP;
      cnt        <= '0;
      rr_ptr     <= '0;
      rand_valid <= '0;
      rand_data  <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      rr_ptr     <= rr_ptr_nxt;
      rand_valid <= rand_valid_nxt;
      rand_data  <= rand_data_nxt;
    end
  end

  // Next-state, LFSR control and grant decision; a seed load aborts anything.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    rr_ptr_nxt     = rr_ptr;
    rand_valid_nxt = '0;
    rand_data_nxt  = rand_data;
    lfsr_en        = 1'b0;
    lfsr_load      = 1'b0;
    if (seed_load) begin
      lfsr_load = 1'b1;
      state_nxt = WARMUP;
      cnt_nxt   = '0;
    end else begin
      case (state)
        WARMUP: begin
          lfsr_en = 1'b1;
          if (cnt == LAST_WARM) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        IDLE: begin
          if (win_found) begin
            rand_data_nxt  = lfsr_q;
            rand_valid_nxt = NUM_REQ'(1) << win_idx;
            rr_ptr_nxt     = (win_idx == LAST_REQ) ? '0 : win_idx + 1'b1;
            state_nxt      = ADVANCE;
            cnt_nxt        = '0;
          end
        end
        ADVANCE: begin
          lfsr_en = 1'b1;
          if (cnt == LAST_STEP) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = WARMUP;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lfsr_rand_arbiter.sv
// ============================================================================
// Module      : tb_lfsr_rand_arbiter
// Description : Directed, table-driven bench for lfsr_rand_arbiter plus a
//               short lfsr_core unit sequence.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lfsr_rand_arbiter;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       seed_load;
  logic [8:0] seed_val;
  logic [3:0] req;
  logic [3:0] rand_valid;
  logic [8:0] rand_data;
  logic       busy;

  logic       core_en;
  logic       core_load;
  logic [8:0] core_val;
  logic [8:0] core_q;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  lfsr_rand_arbiter #(
    .NUM_REQ       (4),
    .LFSR_W        (9),
    .SEED          (9'h0A5),
    .WARMUP_CYCLES (16),
    .STEP          (2)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .seed_load  (seed_load),
    .seed_val   (seed_val),
    .req        (req),
    .rand_valid (rand_valid),
    .rand_data  (rand_data),
    .busy       (busy)
  );

  lfsr_core #(
    .SEED (9'h0A5)
  ) u_core (
    .Clk      (Clk),
    .Reset    (Reset),
    .en       (core_en),
    .load     (core_load),
    .load_val (core_val),
    .q        (core_q)
  );

  typedef struct {
    logic [3:0] req;
    logic       sl;
    logic [8:0] sv;
    logic [3:0] ev;
    logic       eb;
    logic [8:0] ed;
    logic       cp;
    logic [1:0] ep;
  } vec_t;

  vec_t       vq[$];
  logic [8:0] sa [0:63];
  logic [8:0] sb [0:63];

  // Reference LFSR step: XNOR of bits 8 and 3, XOR when all ones.
  function automatic logic [8:0] mstep(input logic [8:0] q);
    logic fb;
    fb = q[3] ^ q[8];
    if (q != 9'h1FF) fb = ~fb;
    return {q[7:0], fb};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] r, input logic sl, input logic [8:0] sv,
                     input logic [3:0] ev, input logic eb, input logic [8:0] ed,
                     input logic cp = 1'b0, input logic [1:0] ep = 2'd0);
    vec_t v;
    v.req = r; v.sl = sl; v.sv = sv; v.ev = ev; v.eb = eb; v.ed = ed; v.cp = cp; v.ep = ep;
    vq.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rn;
    logic [8:0] prev_grant;
    logic       have_prev;
    int         n;

    Reset = 1'b1; seed_load = 1'b0; seed_val = '0; req = '0;
    core_en = 1'b0; core_load = 1'b0; core_val = '0;

    sa[0] = 9'h0A5;
    sb[0] = 9'h1FF;
    for (int i = 1; i < 64; i++) begin
      sa[i] = mstep(sa[i-1]);
      sb[i] = mstep(sb[i-1]);
    end

    // Post-reset warm-up with req[0] held: 15 busy cycles, busy drops, grant.
    for (int i = 0; i < 15; i++) add(4'b0001, 1'b0, 9'h0, 4'b0000, 1'b1, 9'h000);
    add(4'b0001, 1'b0, 9'h0, 4'b0000, 1'b0, 9'h000);
    add(4'b0001, 1'b0, 9'h0, 4'b0001, 1'b1, sa[16], 1'b1, 2'd1);
    add(4'b1111, 1'b0, 9'h0, 4'b0000, 1'b1, sa[16]);
    add(4'b1111, 1'b0, 9'h0, 4'b0000, 1'b0, sa[16]);
    // All requesting: grants 1,2,3,0 three cycles apart.
    for (int k = 1; k <= 4; k++) begin
      rn = (k == 4) ? 4'b0000 : 4'b1111;
      add(4'b1111, 1'b0, 9'h0, 4'b0001 << (k % 4), 1'b1, sa[16+2*k], 1'b1, 2'((k + 1) % 4));
      add(rn, 1'b0, 9'h0, 4'b0000, 1'b1, sa[16+2*k]);
      add(rn, 1'b0, 9'h0, 4'b0000, 1'b0, sa[16+2*k]);
    end
    add(4'b0000, 1'b0, 9'h0, 4'b0000, 1'b0, sa[24]);
    // Lone req[2], then 1001 from pointer 3: bit 3 before bit 0.
    add(4'b0100, 1'b0, 9'h0, 4'b0100, 1'b1, sa[26], 1'b1, 2'd3);
    add(4'b1001, 1'b0, 9'h0, 4'b0000, 1'b1, sa[26]);
    add(4'b1001, 1'b0, 9'h0, 4'b0000, 1'b0, sa[26]);
    add(4'b1001, 1'b0, 9'h0, 4'b1000, 1'b1, sa[28], 1'b1, 2'd0);
    add(4'b0001, 1'b0, 9'h0, 4'b0000, 1'b1, sa[28]);
    add(4'b0001, 1'b0, 9'h0, 4'b0000, 1'b0, sa[28]);
    add(4'b0001, 1'b0, 9'h0, 4'b0001, 1'b1, sa[30], 1'b1, 2'd1);
    // Seed reload during ADVANCE: warm-up restarts, sequence repeats.
    add(4'b0000, 1'b1, 9'h0A5, 4'b0000, 1'b1, sa[30]);
    for (int i = 0; i < 15; i++) add(4'b0010, 1'b0, 9'h0, 4'b0000, 1'b1, sa[30]);
    add(4'b0010, 1'b0, 9'h0, 4'b0000, 1'b0, sa[30]);
    add(4'b0010, 1'b0, 9'h0, 4'b0010, 1'b1, sa[16], 1'b1, 2'd2);
    add(4'b0000, 1'b0, 9'h0, 4'b0000, 1'b1, sa[16]);
    add(4'b0000, 1'b0, 9'h0, 4'b0000, 1'b0, sa[16]);
    add(4'b0100, 1'b0, 9'h0, 4'b0100, 1'b1, sa[18], 1'b1, 2'd3);
    add(4'b0000, 1'b0, 9'h0, 4'b0000, 1'b1, sa[18]);
    add(4'b0000, 1'b0, 9'h0, 4'b0000, 1'b0, sa[18]);
    // Seed 1FF loaded in IDLE beats a pending request; reloaded mid warm-up.
    add(4'b1000, 1'b1, 9'h1FF, 4'b0000, 1'b1, sa[18], 1'b1, 2'd3);
    for (int i = 0; i < 4; i++) add(4'b1000, 1'b0, 9'h0, 4'b0000, 1'b1, sa[18]);
    add(4'b1000, 1'b1, 9'h1FF, 4'b0000, 1'b1, sa[18]);
    for (int i = 0; i < 15; i++) add(4'b1000, 1'b0, 9'h0, 4'b0000, 1'b1, sa[18]);
    add(4'b1000, 1'b0, 9'h0, 4'b0000, 1'b0, sa[18]);
    add(4'b1000, 1'b0, 9'h0, 4'b1000, 1'b1, sb[16], 1'b1, 2'd0);
    add(4'b0000, 1'b0, 9'h0, 4'b0000, 1'b1, sb[16]);
    add(4'b0000, 1'b0, 9'h0, 4'b0000, 1'b0, sb[16]);

    // Reset state.
    repeat (2) @(posedge Clk);
    #1;
    chk("reset rand_valid", 32'(rand_valid), 32'h0);
    chk("reset rand_data", 32'(rand_data), 32'h0);
    chk("reset busy", 32'(busy), 32'h1);
    chk("reset rr_ptr", 32'(dut.rr_ptr), 32'h0);
    chk("reset core_q", 32'(core_q), 32'h0A5);
    Reset = 1'b0;

    have_prev  = 1'b0;
    prev_grant = '0;
    for (int i = 0; i < vq.size(); i++) begin
      req = vq[i].req; seed_load = vq[i].sl; seed_val = vq[i].sv;
      @(posedge Clk);
      #1;
      chk($sformatf("v%0d rand_valid", i), 32'(rand_valid), 32'(vq[i].ev));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vq[i].eb));
      chk($sformatf("v%0d rand_data", i), 32'(rand_data), 32'(vq[i].ed));
      if (vq[i].cp) chk($sformatf("v%0d rr_ptr", i), 32'(dut.rr_ptr), 32'(vq[i].ep));
      if (vq[i].ev != 4'b0000) begin
        if (have_prev) begin
          total++;
          if (rand_data === prev_grant) begin
            bad++;
            $display("FAIL v%0d distinct: got %0h same as previous grant %0h", i, rand_data, prev_grant);
          end
        end
        prev_grant = rand_data;
        have_prev  = 1'b1;
      end
    end
    seed_load = 1'b0;

    // Reset in the middle of a grant pulse clears everything at once.
    req = 4'b0001;
    @(posedge Clk);
    #1;
    chk("pre-reset grant valid", 32'(rand_valid), 32'h1);
    chk("pre-reset grant data", 32'(rand_data), 32'(sb[18]));
    req = 4'b0000;
    #2;
    Reset = 1'b1;
    #1;
    chk("async reset valid", 32'(rand_valid), 32'h0);
    chk("async reset data", 32'(rand_data), 32'h0);
    chk("async reset busy", 32'(busy), 32'h1);
    chk("async reset rr_ptr", 32'(dut.rr_ptr), 32'h0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    req = 4'b0100;
    n = 0;
    while (rand_valid == 4'b0000 && n < 40) begin
      @(posedge Clk);
      #1;
      n++;
    end
    chk("post-reset grant latency", 32'(n), 32'd17);
    chk("post-reset grant valid", 32'(rand_valid), 32'h4);
    chk("post-reset grant data", 32'(rand_data), 32'(sa[16]));
    req = 4'b0000;

    // lfsr_core stepping and lockup escape.
    core_load = 1'b1; core_val = 9'h0A5;
    @(posedge Clk); #1;
    core_load = 1'b0; core_en = 1'b1;
    @(posedge Clk); #1;
    core_en = 1'b0;
    chk("core step 0A5", 32'(core_q), 32'h14B);
    @(posedge Clk); #1;
    chk("core hold", 32'(core_q), 32'h14B);
    core_load = 1'b1; core_val = 9'h1FF;
    @(posedge Clk); #1;
    core_load = 1'b0;
    chk("core load 1FF", 32'(core_q), 32'h1FF);
    core_en = 1'b1;
    @(posedge Clk); #1;
    core_en = 1'b0;
    chk("core lockup escape", 32'(core_q), 32'h1FE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
